vm_coin_dispenser: RTL
======================

VM_COIN_DISPENSER -- requirements
Module: vm_coin_dispenser

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 i_req_valid  input  1  return request from merchant stage.
REQ-004 o_req_ready  output  1  high only in IDLE; request accepted when i_req_valid and o_req_ready are both high.
REQ-005 i_req_amount  input  `kTotalBits  amount to return, sampled on accept.
REQ-006 o_coin_valid  output  1  a coin is offered on o_coin.
REQ-007 o_coin  output  `kNumCoins  one-hot denomination offered; zero when o_coin_valid is low.
REQ-008 i_coin_ready  input  1  coin mechanism takes the offered coin.
REQ-009 o_done  output  1  one-cycle pulse at the end of a request.
REQ-010 o_remainder  output  `kTotalBits  undispensable residue; valid while o_done is high, otherwise holds its last value.
REQ-011 o_busy  output  1  high in every state except IDLE.
REQ-012 i_refill_valid / i_refill_coin[`kNumCoins] / i_refill_count[7:0]  input  stock refill, one-hot coin; present only with the macro.
REQ-013 o_stock_empty  output  `kNumCoins  per-coin stock is zero; present only with the macro.

Function
REQ-014 FSM states: IDLE, SELECT, EMIT, DONE, encoded in 2 bits.
REQ-015 IDLE: on accept, latch i_req_amount into the remaining register; go to DONE if the amount is 0, else go to SELECT.
REQ-016 SELECT, one cycle: pick the highest-index coin i with kCoinValue[i] <= remaining (and stock[i] > 0 with the macro); if found, register it into o_coin and go to EMIT; else go to DONE.
REQ-017 EMIT: o_coin_valid high, o_coin stable until handshake; on i_coin_ready, subtract kCoinValue[i] from remaining (and decrement stock[i] with the macro).
REQ-018 EMIT after handshake: go to DONE if the new remaining is 0, else go to SELECT; while i_coin_ready is low, stay in EMIT indefinitely.
REQ-019 DONE, one cycle: o_done=1, o_remainder=remaining; next state IDLE, remaining cleared.
REQ-020 Minimum latency: 2 cycles per coin plus 1 DONE cycle after accept; a request for 0 gives o_done in the cycle after accept.
REQ-021 Remaining never underflows: a coin is selected only if its value <= remaining.
REQ-022 i_req_valid is ignored outside IDLE; a new request can be accepted the cycle after DONE.

Reset
REQ-023 Reset returns the FSM to IDLE from any state; an offered coin is withdrawn the same edge, with no handshake completed.
REQ-024 Reset values: o_coin_valid=0, o_coin=0, o_done=0, o_remainder=0, remaining=0, o_busy=0, o_req_ready=1 after reset deasserts.
REQ-025 With the macro, reset sets every stock[i] to kInitStock and o_stock_empty to 0.

Configuration
REQ-026 Macro VM_DISPENSER_INVENTORY_EN defined: 8-bit per-coin stock counters, refill port, and o_stock_empty; SELECT skips coins with empty stock.
REQ-027 Refill: on i_refill_valid, stock[i] += i_refill_count, saturating at 255.
REQ-028 Refill in the same cycle as a dispense of the same coin: stock nets to min(255, stock + count - 1).
REQ-029 Macro undefined: stock is unlimited; no counters or refill/stock ports; o_remainder is always 0 for amounts that are multiples of kCoinValue[0].

Structure
REQ-030 kNumCoins, kTotalBits, kCoinValue0..2 (100/500/1000), kInitStock (8), and FSM state encodings belong in vending_machine_def.v.
REQ-031 One sub-module, vm_coin_select: combinational highest-fit picker taking remaining and stock-nonzero mask, returning one-hot coin and a found flag.

Verification
REQ-032 Request 1600, i_coin_ready=1 -> coins 1000, 500, 100 on cycles 2, 4, 6 after accept; o_done on cycle 7; o_remainder=0.
REQ-033 Request 1000, i_coin_ready low for 5 cycles -> o_coin_valid with o_coin=1000 held stable for 5 cycles; exactly one coin delivered; o_done afterwards.
REQ-034 Macro on, stock[1000]=0, request 2000 -> four 500 coins, then o_done with remainder 0; o_stock_empty[2]=1 throughout.
REQ-035 Macro on, stock[100]=1, stock[500]=stock[1000]=0, request 250 -> one 100 coin, then o_done with o_remainder=150.
REQ-036 Reset asserted in EMIT of request 600 -> o_coin_valid=0 the next cycle, FSM in IDLE, no o_done; a following request of 100 completes normally.
REQ-037 Macro on, refill of 250 on coin 100 while it dispenses from stock 8 -> stock saturates at 255, not 257 or 254.

Source files
------------

// File: rtl/vm_coin_dispenser_pkg.sv
// Shared constants, types and helpers for the vending-machine coin dispenser.
// The optional stock inventory is enabled by defining VM_DISPENSER_INVENTORY_EN.
package vm_coin_dispenser_pkg;

  // Coin set: index 0 is the smallest denomination, index 2 the largest.
  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 16;

  localparam logic [kTotalBits-1:0] kCoinValue0 = 16'd100;
  localparam logic [kTotalBits-1:0] kCoinValue1 = 16'd500;
  localparam logic [kTotalBits-1:0] kCoinValue2 = 16'd1000;

  // Starting stock for every denomination when the inventory is enabled.
  localparam logic [7:0] kInitStock = 8'd8;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef logic [kNumCoins-1:0]  coin_t;
  typedef logic [kTotalBits-1:0] amount_t;

  // Face value of the denomination at a given index.
  function automatic amount_t coin_value(input int idx);
    amount_t v;
    case (idx)
      0:       v = kCoinValue0;
      1:       v = kCoinValue1;
      default: v = kCoinValue2;
    endcase
    return v;
  endfunction

  // Face value of a one-hot coin vector (zero for an empty vector).
  function automatic amount_t coin_value_of(input coin_t onehot);
    amount_t v;
    v = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (onehot[i]) begin
        v = v | coin_value(i);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/vm_coin_dispenser_select.sv
// Combinational highest-fit coin picker: returns the largest available coin
// whose value does not exceed the remaining amount.
module vm_coin_select
  import vm_coin_dispenser_pkg::*;
(
  input  logic [kTotalBits-1:0] i_remaining,
  input  logic [kNumCoins-1:0]  i_avail,
  output logic [kNumCoins-1:0]  o_coin,
  output logic                  o_found
);

  // Scan upward so a later (larger) fitting coin overrides a smaller one.
  always_comb begin
    o_coin  = '0;
    o_found = 1'b0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_avail[i] && (coin_value(i) <= i_remaining)) begin
        o_coin    = '0;
        o_coin[i] = 1'b1;
        o_found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vm_coin_dispenser.sv
// Coin dispenser: accepts a return amount and pays it out greedily, one coin
// per handshake, largest denomination first. Any residue that cannot be paid
// is reported on o_remainder alongside the o_done pulse.
// Define VM_DISPENSER_INVENTORY_EN to add per-coin stock counters, a refill
// port and o_stock_empty; without it stock is unlimited.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side is accepted only in IDLE (o_req_ready). On the
// coin side o_coin_valid and o_coin stay stable until i_coin_ready is seen;
// ready is ignored while valid is low.
module vm_coin_dispenser
  import vm_coin_dispenser_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [kTotalBits-1:0] i_req_amount,
  output logic                  o_coin_valid,
  output logic [kNumCoins-1:0]  o_coin,
  input  logic                  i_coin_ready,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_remainder,
  output logic                  o_busy,
`ifdef VM_DISPENSER_INVENTORY_EN
  input  logic                  i_refill_valid,
  input  logic [kNumCoins-1:0]  i_refill_coin,
  input  logic [7:0]            i_refill_count,
  output logic [kNumCoins-1:0]  o_stock_empty,
`endif
  output logic [1:0]            o_dbg_state
);

  logic [1:0]            state_q, state_d;
  logic [kTotalBits-1:0] remaining_q, remaining_d;
  logic [kNumCoins-1:0]  coin_q, coin_d;
  logic [kTotalBits-1:0] remainder_q, remainder_d;
  logic                  dispense;
  logic [kNumCoins-1:0]  avail;
  logic [kNumCoins-1:0]  sel_coin;
  logic                  sel_found;

  vm_coin_select u_select (
    .i_remaining (remaining_q),
    .i_avail     (avail),
    .o_coin      (sel_coin),
    .o_found     (sel_found)
  );

`ifdef VM_DISPENSER_INVENTORY_EN
  logic [7:0] stock_q   [kNumCoins];
  logic [7:0] stock_d   [kNumCoins];
  logic [9:0] stock_sum [kNumCoins];

  // Net refill and dispense per coin in one step, then clamp to 8 bits.
  always_comb begin
    for (int i = 0; i < kNumCoins; i++) begin
      stock_sum[i] = {2'b00, stock_q[i]};
      if (i_refill_valid && i_refill_coin[i]) begin
        stock_sum[i] = stock_sum[i] + {2'b00, i_refill_count};
      end
      if (dispense && coin_q[i]) begin
        stock_sum[i] = stock_sum[i] - 10'd1;
      end
      stock_d[i] = (stock_sum[i] > 10'd255) ? 8'hFF : stock_sum[i][7:0];
      avail[i]         = (stock_q[i] != 8'd0);
      o_stock_empty[i] = (stock_q[i] == 8'd0);
    end
  end

  // Stock counters restart full on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < kNumCoins; i++) begin
      if (reset) begin
        stock_q[i] <= kInitStock;
      end else begin
        stock_q[i] <= stock_d[i];
      end
    end
  end
`else
  // Unlimited stock: every denomination is always available.
  always_comb begin
    avail = '1;
  end
`endif

  // Next-state, remaining amount and offered-coin logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    remainder_d = remainder_q;
    dispense    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          remaining_d = i_req_amount;
          state_d     = (i_req_amount == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          coin_d  = sel_coin;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_EMIT: begin
        if (i_coin_ready) begin
          dispense    = 1'b1;
          remaining_d = remaining_q - coin_value_of(coin_q);
          coin_d      = '0;
          state_d     = (remaining_d == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        coin_d      = '0;
      end
    endcase
    // Capture the residue as DONE is entered so it is visible with o_done
    // and held afterwards.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      remainder_d = remaining_d;
    end
  end

  // State registers; reset withdraws any offered coin on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      coin_q      <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      remainder_q <= remainder_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_req_ready  = (state_q == ST_IDLE);
    o_busy       = (state_q != ST_IDLE);
    o_coin_valid = (state_q == ST_EMIT);
    o_coin       = coin_q;
    o_done       = (state_q == ST_DONE);
    o_remainder  = remainder_q;
    o_dbg_state  = state_q;
  end

endmodule
